// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA encodings used by the decode-stage issue logic:
// opcode/funct values, stall cause codes, the IF/ID holding-state
// encoding and the decoded instruction class bundle.
package mips_isa_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0]) that touch the HI/LO unit
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    // Reason the held instruction is not issuing
    typedef enum logic [1:0] {
        STALL_NONE         = 2'd0,
        STALL_LOAD_USE     = 2'd1,
        STALL_MULDIV       = 2'd2,
        STALL_BACKPRESSURE = 2'd3
    } stall_cause_t;

    // IF/ID register occupancy
    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    // Decoded class bits of the held instruction
    typedef struct packed {
        logic is_load;     // any load opcode
        logic reads_rs;    // rs is a source register
        logic reads_rt;    // rt is a source register
        logic is_md_op;    // MULT/MULTU/DIV/DIVU, starts the md unit
        logic reads_hilo;  // MFHI/MFLO, consumes the md result
    } instr_class_t;

    // True for the funct codes that start a multiply/divide
    function automatic logic is_md_funct(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection for the instruction held in IF/ID.
// Classifies the instruction and flags load-use and multiply/divide
// busy hazards against the previously issued instruction state.
module hazard_detect
    import mips_isa_pkg::*;
(
    input  logic [31:0]  instr,
    input  logic         prev_load,
    input  logic [4:0]   prev_rt,
    input  logic         md_busy,
    output logic         load_hz,
    output logic         md_hz,
    output instr_class_t cls
);

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign funct  = instr[5:0];

    // rd/shamt do not participate in issue decisions
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[15:6];

    // Classify the held instruction and evaluate both data hazards
    always_comb begin
        cls     = '0;
        load_hz = 1'b0;
        md_hz   = 1'b0;

        cls.is_load    = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW) ||
                         (opcode == OP_LBU) || (opcode == OP_LHU);
        cls.reads_rs   = !((opcode == OP_J) || (opcode == OP_JAL));
        cls.reads_rt   = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                         (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
        cls.is_md_op   = (opcode == OP_RTYPE) && is_md_funct(funct);
        cls.reads_hilo = (opcode == OP_RTYPE) && ((funct == FN_MFHI) || (funct == FN_MFLO));

        // $0 is hardwired, so a load targeting it never creates a dependency
        load_hz = prev_load && (prev_rt != 5'd0) &&
                  ((cls.reads_rs && (rs == prev_rt)) || (cls.reads_rt && (rt == prev_rt)));

        // Anything that touches HI/LO waits for the md unit to drain
        md_hz = md_busy && (cls.is_md_op || cls.reads_hilo);
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue controller. Holds the IF/ID register and decides
// each cycle whether the held instruction issues, inserting a bubble on
// load-use, waiting on the multiply/divide unit, honouring EX
// backpressure and dropping the entry on a branch flush.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Upstream, if_ready never depends on if_valid. Downstream, id_valid is
// raised independently of id_ready and, once raised, stays raised with
// id_instr stable until id_ready accepts it (only flush may withdraw it).
module decode_issue_ctrl
    import mips_isa_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           if_valid,
    input  logic [31:0]                    if_instr,
    output logic                           if_ready,
    output logic                           id_valid,
    output logic [31:0]                    id_instr,
    input  logic                           id_ready,
    input  logic                           flush,
    output logic [1:0]                     stall_cause,
    output hold_state_t                    dbg_state,
    output logic [$clog2(MD_CYCLES+1)-1:0] dbg_md_cnt
);

    localparam int CW = $clog2(MD_CYCLES + 1);

    hold_state_t  state_q;
    hold_state_t  state_d;
    logic [31:0]  instr_q;
    logic         prev_load_q;
    logic [4:0]   prev_rt_q;
    logic [CW-1:0] md_cnt_q;

    logic         hold_valid;
    logic         issue;
    logic         fetch_xfer;
    logic         load_hz;
    logic         md_hz;
    instr_class_t cls;

    assign hold_valid = (state_q == HOLD_FULL);
    assign id_instr   = instr_q;
    assign dbg_state  = state_q;
    assign dbg_md_cnt = md_cnt_q;

    hazard_detect u_hazard_detect (
        .instr     (instr_q),
        .prev_load (prev_load_q),
        .prev_rt   (prev_rt_q),
        .md_busy   (md_cnt_q != '0),
        .load_hz   (load_hz),
        .md_hz     (md_hz),
        .cls       (cls)
    );

    // Source-register and HI/LO class bits are consumed inside hazard_detect
    logic unused_cls_bits;
    assign unused_cls_bits = cls.reads_rs ^ cls.reads_rt ^ cls.reads_hilo;

    // Occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HOLD_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next state: fill on transfer, drain on issue without refill or flush
    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD_EMPTY: begin
                if (fetch_xfer) state_d = HOLD_FULL;
            end
            HOLD_FULL: begin
                if (flush)                     state_d = HOLD_EMPTY;
                else if (issue && !fetch_xfer) state_d = HOLD_EMPTY;
                else                           state_d = HOLD_FULL;
            end
            default: state_d = HOLD_EMPTY;
        endcase
    end

    // Handshake outputs and stall cause; flush outranks every hazard
    always_comb begin
        id_valid    = hold_valid & ~load_hz & ~md_hz & ~flush;
        issue       = id_valid & id_ready;
        if_ready    = ~hold_valid | issue | flush;
        fetch_xfer  = if_valid & if_ready & ~flush;
        stall_cause = STALL_NONE;
        if (hold_valid && !flush) begin
            if (load_hz)        stall_cause = STALL_LOAD_USE;
            else if (md_hz)     stall_cause = STALL_MULDIV;
            else if (!id_ready) stall_cause = STALL_BACKPRESSURE;
        end
    end

    // IF/ID data register; keeps its last word when the entry drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= 32'h0;
        end else if (fetch_xfer) begin
            instr_q <= if_instr;
        end
    end

    // Record what issued this cycle; a bubble clears prev_load so load-use lasts one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_load_q <= 1'b0;
            prev_rt_q   <= 5'd0;
        end else begin
            prev_load_q <= issue & cls.is_load;
            prev_rt_q   <= instr_q[20:16];
        end
    end

    // Multiply/divide busy counter; flush leaves it alone since the op already committed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt_q <= '0;
        end else if (issue && cls.is_md_op) begin
            md_cnt_q <= CW'(MD_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_q <= md_cnt_q - CW'(1);
        end
    end

endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Issue controller for the decode stage of the MIPS pipeline. It holds the IF/ID pipeline register and uses the opcode, rs, rt and funct fields to decide each cycle whether the held instruction may issue to the decoder/EX stage. It inserts a bubble for load-use hazards, stalls on the multiply/divide unit while it is busy, honours downstream backpressure, and discards the wrong-path instruction on a branch flush.

## Interface
- MD_CYCLES, 32, cycles the multiply/divide unit is busy after a MULT/MULTU/DIV/DIVU issues.
- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  fetched instruction word.
- if_ready  out  1  IF/ID register can accept this cycle.
- id_valid  out  1  held instruction issues this cycle.
- id_instr  out  32  IF/ID register contents, fed to the decoder.
- id_ready  in  1  EX stage accepts.
- flush  in  1  taken branch/jump resolved; kill the IF/ID entry.
- stall_cause  out  2  0 none, 1 load-use, 2 muldiv busy, 3 downstream backpressure.

## Operation
- Field extraction: opcode [31:26], rs [25:21], rt [20:16], funct [5:0].
- Load: opcode is 0x20, 0x21, 0x23, 0x24 or 0x25.
- Reads rs: every opcode except J (0x02) and JAL (0x03).
- Reads rt: R-type (opcode 0), BEQ/BNE (0x04/0x05), and stores (0x28, 0x29, 0x2B).
- State:
  - hold_valid: the IF/ID register is full.
  - prev_load (1 bit) and prev_rt (5 bits): describe the instruction issued in the previous cycle.
  - md_cnt: width $clog2(MD_CYCLES+1).
- load_hz: prev_load, the held instruction reads a register equal to prev_rt, and prev_rt != 0.
- md_hz: md_cnt != 0 and the held instruction is R-type with funct 0x10, 0x12, 0x18, 0x19, 0x1A or 0x1B.
- Hazard priority, when the held instruction is valid: load_hz (1), then md_hz (2), then !id_ready (3). stall_cause reports the winning cause.
- issue = hold_valid & !load_hz & !md_hz & id_ready & !flush.
- id_valid = hold_valid & !load_hz & !md_hz & !flush.
- id_instr always shows the register contents.
- if_ready = !hold_valid | issue | flush.
- Register update:
  - Fetch transfer (if_valid & if_ready & !flush): load if_instr and set hold_valid.
  - Issue with no transfer: clear hold_valid.
  - Flush: clear hold_valid. A same-cycle if_valid is consumed and dropped.
- prev_load/prev_rt update every cycle: prev_load <= issue & held-is-load; prev_rt <= held rt. A bubble cycle therefore clears prev_load, so a load-use stall lasts exactly one cycle.
- md_cnt:
  - Loads MD_CYCLES when a MULT/MULTU/DIV/DIVU issues.
  - Otherwise decrements when non-zero; saturates at 0.
  - Flush does not touch md_cnt, because an in-flight op commits.
- FSM, 2 states:
  - EMPTY → FULL on a fetch transfer.
  - FULL → EMPTY on issue with no refill, or on flush.
  - FULL → FULL on a stall, or on issue with a simultaneous refill.

## Timing
- Reset values:
  - hold_valid 0, id_valid 0, id_instr 32'h0, if_ready 1, stall_cause 0.
  - prev_load 0, prev_rt 0, md_cnt 0.
- Reset asserted mid-stall clears all state immediately (asynchronous). The first fetch is accepted on the first edge after deassertion.
- Latency: an instruction accepted at edge N drives id_valid in cycle N+1 if no hazard applies.
- Throughput: one instruction per cycle with back-to-back issue and refill.
- Outputs other than id_instr are combinational from registered state plus id_ready and flush. There is no combinational path from if_valid to if_ready.
- Flush overrides every hazard and backpressure in the same cycle.
- A MULT issued at edge N blocks a dependent MFLO through cycle N+MD_CYCLES; the MFLO issues in cycle N+MD_CYCLES+1.

## Structure
- Shared package `mips_isa_pkg` holds:
  - opcode/funct localparams (LB, LH, LW, LBU, LHU, SB, SH, SW, BEQ, BNE, J, JAL, MFHI, MFLO, MULT, MULTU, DIV, DIVU);
  - the stall_cause encodings.
- Sub-module `hazard_detect` (combinational):
  - inputs: held instruction, prev_load, prev_rt, md_cnt != 0;
  - outputs: load_hz, md_hz and the decoded class bits.
- The FSM and the counters stay in the top module.

## Test plan
- Load-use: 0x8E080000 (lw $8) then 0x010A4820 (add reads $8).
  - Required: the add sees id_valid=0 with stall_cause=1 for exactly one cycle, then issues.
- Load to $0: 0x8E000000 then 0x00004820.
  - Required: no bubble; the two instructions issue in consecutive cycles.
- Multiply: MD_CYCLES=4, 0x01090018 (mult) then 0x00005012 (mflo).
  - Required: the mflo is held 4 cycles with stall_cause=2, then issues.
- Backpressure: id_ready=0 for 3 cycles with the register full.
  - Required: stall_cause=3 and if_ready=0 during those cycles; id_instr stays stable; no instruction is lost or duplicated.
- Flush during a load-use stall, with if_valid=1 in the same cycle.
  - Required: the held and incoming instructions are both dropped, the next cycle has id_valid=0, and md_cnt is unchanged.
- Reset asserted mid-stall.
  - Required: all outputs take their reset values immediately; after release, the first fetch issues one cycle after acceptance.
